axi4_lite_gpio: RTL

//  Parametrised AXI4-Lite GPIO slave; replaces the fixed 4-bit debug LED register in the SoC top.

---
 rtl/gpio_pkg.sv | 43 ++++
 rtl/gpio_sync.sv | 44 ++++
 rtl/axi4_lite_gpio.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_pkg.sv
// -----------------------------------------------------------------------------
// gpio_pkg
// Shared definitions for the AXI4-Lite GPIO slave:
//   - register select codes (address bits [4:2])
//   - write / read channel FSM state enums
//   - AXI response code and a byte-strobe to bit-mask helper
// -----------------------------------------------------------------------------
package gpio_pkg;

  // Register select = address bits [4:2]
  localparam logic [2:0] REG_DATA_OUT = 3'd0;  // RW
  localparam logic [2:0] REG_DATA_IN  = 3'd1;  // RO, synchronised pins
  localparam logic [2:0] REG_DIR      = 3'd2;  // RW, 1 = drive
  localparam logic [2:0] REG_SET      = 3'd3;  // WO, DATA_OUT |= data
  localparam logic [2:0] REG_CLR      = 3'd4;  // WO, DATA_OUT &= ~data
  localparam logic [2:0] REG_TGL      = 3'd5;  // WO, DATA_OUT ^= data
  localparam logic [2:0] REG_IRQ_EN   = 3'd6;  // RW
  localparam logic [2:0] REG_IRQ_STAT = 3'd7;  // R/W1C

  localparam logic [1:0] AXI_OKAY = 2'b00;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,  // waiting for AW and/or W
    W_WAIT_D = 2'd1,  // address held, waiting for data
    W_WAIT_A = 2'd2,  // data held, waiting for address
    W_RESP   = 2'd3   // write response pending
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,    // ready for an address
    R_DATA = 1'b1     // read data presented
  } r_state_t;

  // Expand the 4 byte-lane strobes into a 32-bit bit mask.
  function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
    logic [31:0] mask;
    for (int k = 0; k < 4; k++) begin
      mask[8*k +: 8] = {8{strb[k]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/gpio_sync.sv
// -----------------------------------------------------------------------------
// gpio_sync
// Multi-flop synchroniser for asynchronous GPIO inputs plus one extra flop
// for rising-edge detection.
// Ports:
//   clk   in            system clock
//   rst   in            synchronous reset, active-low
//   din   in  [WIDTH]   asynchronous pin inputs
//   sync  out [WIDTH]   synchronised pin levels (last chain stage)
//   rise  out [WIDTH]   one-cycle pulse on a 0->1 transition of sync
// -----------------------------------------------------------------------------
module gpio_sync
  import gpio_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise
);

  // chain[0] is the metastability-catching stage, chain[SYNC_STAGES-1] is safe.
  logic [SYNC_STAGES-1:0][WIDTH-1:0] chain;
  logic [WIDTH-1:0]                  prev;

  // NOTE: clocked state uses non-blocking <= so every flop samples the
  // pre-edge value of its neighbour; blocking = here would collapse the chain.
  always_ff @(posedge clk) begin
    if (!rst) begin
      chain <= '0;
      prev  <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], din};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign sync = chain[SYNC_STAGES-1];
  assign rise = sync & ~prev;

endmodule

// File: rtl/axi4_lite_gpio.sv
// -----------------------------------------------------------------------------
// axi4_lite_gpio
// Parametrised AXI4-Lite GPIO slave: output data, direction, atomic
// SET/CLR/TGL, synchronised inputs and per-pin rising-edge interrupts.
// Write and read channels are independent, one outstanding transaction each.
// Ports:
//   clk, rst                      clock, synchronous active-low reset
//   s_aw*/s_w*/s_b*               AXI4-Lite write address / data / response
//   s_ar*/s_r*                    AXI4-Lite read address / data
//   gpio_i  in  [WIDTH]           asynchronous pin inputs
//   gpio_o  out [WIDTH]           DATA_OUT
//   gpio_oe out [WIDTH]           DIR (1 = drive)
//   irq     out                   registered |(IRQ_STAT & IRQ_EN)
// Register bits at or above WIDTH read 0 and ignore writes.
// -----------------------------------------------------------------------------
module axi4_lite_gpio
  import gpio_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] OUT_RST     = '0
) (
  input  logic             clk,
  input  logic             rst,
  // write address
  input  logic [31:0]      s_awaddr,
  input  logic [2:0]       s_awprot,
  input  logic             s_awvalid,
  output logic             s_awready,
  // write data
  input  logic [31:0]      s_wdata,
  input  logic [3:0]       s_wstrb,
  input  logic             s_wvalid,
  output logic             s_wready,
  // write response
  output logic [1:0]       s_bresp,
  output logic             s_bvalid,
  input  logic             s_bready,
  // read address
  input  logic [31:0]      s_araddr,
  input  logic [2:0]       s_arprot,
  input  logic             s_arvalid,
  output logic             s_arready,
  // read data
  output logic [31:0]      s_rdata,
  output logic [1:0]       s_rresp,
  output logic             s_rvalid,
  input  logic             s_rready,
  // pins
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  w_state_t         w_state, w_next;
  r_state_t         r_state, r_next;

  logic             aw_hs, w_hs, ar_hs, r_hs;

  // Whichever half of a write arrives first is held here.
  logic [2:0]       aw_sel_q;
  logic [WIDTH-1:0] wdata_q;
  logic [3:0]       wstrb_q;

  logic             wr_en;
  logic [2:0]       wr_sel;
  logic [WIDTH-1:0] wr_data;
  logic [3:0]       wr_strb;
  logic [31:0]      wr_mask_full;
  logic [WIDTH-1:0] wr_mask;
  logic [WIDTH-1:0] wr_bits;

  logic [WIDTH-1:0] data_out, dir, irq_en, irq_stat;
  logic [WIDTH-1:0] data_in, rise, w1c;

  logic [31:0]      rd_mux;
  logic [31:0]      rdata_q;

  // ---------------------------------------------------------------------------
  // Input synchroniser and edge detect
  // ---------------------------------------------------------------------------
  gpio_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (gpio_i),
    .sync (data_in),
    .rise (rise)
  );

  // ---------------------------------------------------------------------------
  // Write channel FSM
  // ---------------------------------------------------------------------------
  assign s_awready = (w_state == W_IDLE) || (w_state == W_WAIT_A);
  assign s_wready  = (w_state == W_IDLE) || (w_state == W_WAIT_D);
  assign s_bvalid  = (w_state == W_RESP);
  assign s_bresp   = AXI_OKAY;

  assign aw_hs = s_awvalid & s_awready;
  assign w_hs  = s_wvalid  & s_wready;

  always_ff @(posedge clk) begin
    if (!rst) w_state <= W_IDLE;
    else      w_state <= w_next;
  end

  always_comb begin
    // NOTE: default assigned first so every path drives w_next; a missing
    // branch would otherwise infer a latch.
    w_next = w_state;
    unique case (w_state)
      W_IDLE: begin
        if (aw_hs && w_hs) w_next = W_RESP;
        else if (aw_hs)    w_next = W_WAIT_D;
        else if (w_hs)     w_next = W_WAIT_A;
      end
      W_WAIT_D: if (w_hs)     w_next = W_RESP;
      W_WAIT_A: if (aw_hs)    w_next = W_RESP;
      W_RESP:   if (s_bready) w_next = W_IDLE;
      default:                w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      aw_sel_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else begin
      if (aw_hs) aw_sel_q <= s_awaddr[4:2];
      if (w_hs) begin
        wdata_q <= s_wdata[WIDTH-1:0];
        wstrb_q <= s_wstrb;
      end
    end
  end

  // The register update happens on the edge that enters W_RESP. On that edge
  // the completing half comes straight from the bus, the other from the
  // holding registers.
  assign wr_en        = (w_next == W_RESP) && (w_state != W_RESP);
  assign wr_sel       = aw_hs ? s_awaddr[4:2]      : aw_sel_q;
  assign wr_data      = w_hs  ? s_wdata[WIDTH-1:0] : wdata_q;
  assign wr_strb      = w_hs  ? s_wstrb            : wstrb_q;
  assign wr_mask_full = strb_to_mask(wr_strb);
  assign wr_mask      = wr_mask_full[WIDTH-1:0];
  assign wr_bits      = wr_data & wr_mask;

  assign w1c = (wr_en && (wr_sel == REG_IRQ_STAT)) ? wr_bits : '0;

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      data_out <= OUT_RST;
      dir      <= '0;
      irq_en   <= '0;
      irq_stat <= '0;
      irq      <= 1'b0;
    end else begin
      if (wr_en) begin
        case (wr_sel)
          REG_DATA_OUT: data_out <= (data_out & ~wr_mask) | wr_bits;
          REG_DIR:      dir      <= (dir      & ~wr_mask) | wr_bits;
          REG_SET:      data_out <= data_out | wr_bits;
          REG_CLR:      data_out <= data_out & ~wr_bits;
          REG_TGL:      data_out <= data_out ^ wr_bits;
          REG_IRQ_EN:   irq_en   <= (irq_en   & ~wr_mask) | wr_bits;
          default:      ;  // DATA_IN read-only; IRQ_STAT handled below
        endcase
      end
      // A new edge wins over a W1C of the same bit in the same cycle.
      irq_stat <= (irq_stat & ~w1c) | rise;
      irq      <= |(irq_stat & irq_en);
    end
  end

  assign gpio_o  = data_out;
  assign gpio_oe = dir;

  // ---------------------------------------------------------------------------
  // Read channel FSM
  // ---------------------------------------------------------------------------
  assign s_arready = (r_state == R_IDLE);
  assign s_rvalid  = (r_state == R_DATA);
  assign s_rdata   = rdata_q;
  assign s_rresp   = AXI_OKAY;

  assign ar_hs = s_arvalid & s_arready;
  assign r_hs  = s_rvalid  & s_rready;

  always_ff @(posedge clk) begin
    if (!rst) r_state <= R_IDLE;
    else      r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    unique case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_DATA;
      R_DATA:  if (r_hs)  r_next = R_IDLE;
      default:            r_next = R_IDLE;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    case (s_araddr[4:2])
      REG_DATA_OUT: rd_mux = 32'(data_out);
      REG_DATA_IN:  rd_mux = 32'(data_in);
      REG_DIR:      rd_mux = 32'(dir);
      REG_IRQ_EN:   rd_mux = 32'(irq_en);
      REG_IRQ_STAT: rd_mux = 32'(irq_stat);
      default:      rd_mux = '0;  // SET/CLR/TGL are write-only
    endcase
  end

  // Captured only on the AR handshake, so data stays stable while rready=0.
  always_ff @(posedge clk) begin
    if (!rst)       rdata_q <= '0;
    else if (ar_hs) rdata_q <= rd_mux;
  end

  // Bus fields this slave deliberately ignores.
  logic unused_bits;
  assign unused_bits = ^{s_awprot, s_arprot,
                         s_awaddr[31:5], s_awaddr[1:0],
                         s_araddr[31:5], s_araddr[1:0],
                         s_wdata, wr_mask_full};

endmodule
